// File: rtl/openfire_alu_compare_unit.sv
// OpenFire EXECUTE datapath: 32-bit ALU with multicycle multiply,
// plus an independent branch/compare condition evaluator.
//
// Ports:
//   clock, reset (sync, active-high), stall (freezes internal state)
//   a, b, c_in, fns     : ALU operands, carry-in and function select
//   alu_result, c_out   : ALU result and carry/shift-out
//   alu_multicycle_instr(_complete) : MUL in progress / result valid
//   dmem_addr           : a+b for the data-memory port
//   cmp_in0, cmp_in1, cmp_fns, cmp_out : branch condition evaluator
module openfire_alu_compare_unit #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  input  logic [3:0]  fns,
  output logic [31:0] alu_result,
  output logic        c_out,
  output logic        alu_multicycle_instr,
  output logic        alu_multicycle_instr_complete,
  output logic [31:0] dmem_addr,
  input  logic [31:0] cmp_in0,
  input  logic [31:0] cmp_in1,
  input  logic [2:0]  cmp_fns,
  output logic        cmp_out
);

  localparam int CW =
    (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] TERM =
    CW'(MUL_LATENCY - 1);

  localparam logic [3:0] F_ADD    = 4'd0;
  localparam logic [3:0] F_OR     = 4'd1;
  localparam logic [3:0] F_AND    = 4'd2;
  localparam logic [3:0] F_XOR    = 4'd3;
  localparam logic [3:0] F_SEXT8  = 4'd4;
  localparam logic [3:0] F_SEXT16 = 4'd5;
  localparam logic [3:0] F_SRA    = 4'd6;
  localparam logic [3:0] F_SRL    = 4'd7;
  localparam logic [3:0] F_SRC    = 4'd8;
  localparam logic [3:0] F_MUL    = 4'd11;
  localparam logic [3:0] F_BSRL   = 4'd12;
  localparam logic [3:0] F_BSRA   = 4'd13;
  localparam logic [3:0] F_BSLL   = 4'd14;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_prod;

  logic          w_is_mul;
  logic          w_term;
  logic          w_cpl;
  logic [31:0]   w_prod;
  logic [31:0]   w_mul_res;
  logic [32:0]   w_sum;
  logic [4:0]    w_sh;
  logic [31:0]   w_bsra;
  logic          w_zero;
  logic          w_neg;

  assign w_is_mul = (fns == F_MUL);
  assign w_term   = (r_cnt == TERM);
  assign w_prod   = a * b;

  // Operands are held stable for the whole MUL, so the product
  // captured on any earlier cycle equals the current one.
  assign w_mul_res =
    (MUL_LATENCY == 1) ? w_prod : r_prod;

  assign w_cpl = w_is_mul & w_term & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_prod <= '0;
    end else if (!stall) begin
      if (w_is_mul) begin
        r_cnt  <= w_term ? '0 : r_cnt + 1'b1;
        r_prod <= w_prod;
      end else begin
        r_cnt  <= '0;
      end
    end
  end

  assign alu_multicycle_instr          = w_is_mul;
  assign alu_multicycle_instr_complete = w_cpl;

  assign w_sum  = {1'b0, a} + {1'b0, b}
                + {32'd0, c_in};
  assign w_sh   = b[4:0];
  assign w_bsra = 32'($signed(a) >>> w_sh);

  assign dmem_addr = a + b;

  always_comb begin
    alu_result = w_sum[31:0];
    c_out      = w_sum[32];
    case (fns)
      F_OR: begin
        alu_result = a | b;
        c_out      = 1'b0;
      end
      F_AND: begin
        alu_result = a & b;
        c_out      = 1'b0;
      end
      F_XOR: begin
        alu_result = a ^ b;
        c_out      = 1'b0;
      end
      F_SEXT8: begin
        alu_result = {{24{a[7]}}, a[7:0]};
        c_out      = 1'b0;
      end
      F_SEXT16: begin
        alu_result = {{16{a[15]}}, a[15:0]};
        c_out      = 1'b0;
      end
      F_SRA: begin
        alu_result = {a[31], a[31:1]};
        c_out      = a[0];
      end
      F_SRL: begin
        alu_result = {1'b0, a[31:1]};
        c_out      = a[0];
      end
      F_SRC: begin
        alu_result = {c_in, a[31:1]};
        c_out      = a[0];
      end
      F_MUL: begin
        alu_result = w_cpl ? w_mul_res : 32'd0;
        c_out      = 1'b0;
      end
      F_BSRL: begin
        alu_result = a >> w_sh;
        c_out      = 1'b0;
      end
      F_BSRA: begin
        alu_result = w_bsra;
        c_out      = 1'b0;
      end
      F_BSLL: begin
        alu_result = a << w_sh;
        c_out      = 1'b0;
      end
      // ADD, CMP, CMPU and the reserved code all use the adder.
      default: begin
        alu_result = w_sum[31:0];
        c_out      = w_sum[32];
      end
    endcase
  end

  assign w_zero = (cmp_in0 == 32'd0);
  assign w_neg  = cmp_in0[31];

  always_comb begin
    cmp_out = 1'b0;
    case (cmp_fns)
      3'd0:    cmp_out = w_zero;
      3'd1:    cmp_out = ~w_zero;
      3'd2:    cmp_out = w_neg;
      3'd3:    cmp_out = w_neg | w_zero;
      3'd4:    cmp_out = ~w_neg & ~w_zero;
      3'd5:    cmp_out = ~w_neg;
      3'd6:    cmp_out = 1'b1;
      default: cmp_out = (cmp_in0 > cmp_in1);
    endcase
  end

endmodule

// File: tb/tb_openfire_alu_compare_unit.sv
// Scoreboard bench for openfire_alu_compare_unit:
// directed vectors, expected values queued, monitor compares.
module tb_openfire_alu_compare_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset, stall, c_in;
  logic [31:0] a, b;
  logic [3:0]  fns;
  logic [31:0] alu_result, dmem_addr;
  logic        c_out, mi, cpl;
  logic [31:0] cmp_in0, cmp_in1;
  logic [2:0]  cmp_fns;
  logic        cmp_out;

  openfire_alu_compare_unit #(.MUL_LATENCY(LAT)) dut (
    .clock(clk), .reset(reset), .stall(stall),
    .a(a), .b(b), .c_in(c_in), .fns(fns),
    .alu_result(alu_result), .c_out(c_out),
    .alu_multicycle_instr(mi),
    .alu_multicycle_instr_complete(cpl),
    .dmem_addr(dmem_addr),
    .cmp_in0(cmp_in0), .cmp_in1(cmp_in1),
    .cmp_fns(cmp_fns), .cmp_out(cmp_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_cmp;
    string       name;
    logic [31:0] res;
    logic        c;
    bit          chk_c;
    logic [31:0] dm;
    bit          chk_dm;
    logic        mi;
    logic        cmp;
    int          cyc;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_mul[$];

  int  tests = 0;
  int  fails = 0;
  bit  chk = 1'b0;
  bit  fin_req = 1'b0;
  bit  fin_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (chk) begin
      if (q_comb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL comb_underflow: no expected entry");
      end else begin
        e = q_comb.pop_front();
        tests++;
        if (e.is_cmp) begin
          if (cmp_out !== e.cmp) begin
            fails++;
            $display("FAIL %s: cmp_out got %b want %b",
                     e.name, cmp_out, e.cmp);
          end
        end else if (alu_result !== e.res ||
                     (e.chk_c && c_out !== e.c) ||
                     (e.chk_dm && dmem_addr !== e.dm) ||
                     mi !== e.mi || cpl !== 1'b0) begin
          fails++;
          $display({"FAIL %s: res %h/%h c %b/%b dm %h/%h",
                    " mi %b/%b cpl %b/0"},
                   e.name, alu_result, e.res, c_out, e.c,
                   dmem_addr, e.dm, mi, e.mi, cpl);
        end
      end
    end
    if (cpl) begin
      tests++;
      if (q_mul.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: cycle %0d res %h",
                 cyc, alu_result);
      end else begin
        e = q_mul.pop_front();
        if (cyc != e.cyc || alu_result !== e.res) begin
          fails++;
          $display("FAIL %s: cycle %0d want %0d res %h want %h",
                   e.name, cyc, e.cyc, alu_result, e.res);
        end
      end
    end
    if (fin_req && !fin_done) begin
      tests++;
      if (q_mul.size() != 0) begin
        fails++;
        $display("FAIL missing_pulse: %0d pending, first %s",
                 q_mul.size(), q_mul[0].name);
      end
      tests++;
      if (q_comb.size() != 0) begin
        fails++;
        $display("FAIL pending_comb: %0d left", q_comb.size());
      end
      fin_done = 1'b1;
    end
  end

  task automatic strobe();
    chk = 1'b1;
    @(negedge clk);
    #1 chk = 1'b0;
  endtask

  task automatic alu_vec(
    input string       name,
    input logic [3:0]  f,
    input logic [31:0] va, vb,
    input logic        vc,
    input logic [31:0] res,
    input logic        ec,
    input bit          chk_c,
    input bit          chk_dm
  );
    exp_t e;
    @(posedge clk);
    #1;
    fns = f; a = va; b = vb; c_in = vc;
    e = '{is_cmp: 1'b0, name: name, res: res, c: ec,
          chk_c: chk_c, dm: va + vb, chk_dm: chk_dm,
          mi: 1'b0, cmp: 1'b0, cyc: 0};
    q_comb.push_back(e);
    strobe();
  endtask

  task automatic cmp_vec(
    input string       name,
    input logic [2:0]  f,
    input logic [31:0] i0, i1,
    input logic        want
  );
    exp_t e;
    @(posedge clk);
    #1;
    cmp_fns = f; cmp_in0 = i0; cmp_in1 = i1;
    e = '{is_cmp: 1'b1, name: name, res: 32'd0, c: 1'b0,
          chk_c: 1'b0, dm: 32'd0, chk_dm: 1'b0,
          mi: 1'b0, cmp: want, cyc: 0};
    q_comb.push_back(e);
    strobe();
  endtask

  task automatic mul_vec(
    input string       name,
    input logic [31:0] va, vb,
    input logic [31:0] want,
    input int          nst
  );
    exp_t e;
    int   k;
    int   ecyc;
    @(posedge clk);
    #1;
    fns = 4'd11; a = va; b = vb; c_in = 1'b0;
    k = cyc;
    ecyc = k + LAT - 1 + nst;
    e = '{is_cmp: 1'b0, name: name, res: want, c: 1'b0,
          chk_c: 1'b0, dm: 32'd0, chk_dm: 1'b0,
          mi: 1'b1, cmp: 1'b0, cyc: ecyc};
    q_mul.push_back(e);
    e.name = {name, "_start"};
    e.res = 32'd0;
    e.chk_c = 1'b1;
    q_comb.push_back(e);
    strobe();
    if (nst > 0) begin
      @(posedge clk);
      #1 stall = 1'b1;
      repeat (nst) @(posedge clk);
      #1 stall = 1'b0;
    end
    do begin
      @(posedge clk);
      #1;
    end while (cyc <= ecyc);
    fns = 4'd0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; stall = 1'b0; c_in = 1'b0;
    fns = 4'd11; a = 32'd7; b = 32'd6;
    cmp_in0 = '0; cmp_in1 = '0; cmp_fns = 3'd0;
    repeat (4) @(posedge clk);
    #1;
    e = '{is_cmp: 1'b0, name: "reset_state", res: 32'd0,
          c: 1'b0, chk_c: 1'b1, dm: 32'd13, chk_dm: 1'b1,
          mi: 1'b1, cmp: 1'b0, cyc: 0};
    q_comb.push_back(e);
    strobe();
    @(posedge clk);
    #1;
    reset = 1'b0;
    fns = 4'd0;

    alu_vec("add_c0", 4'd0, 32'hFFFFFFFF, 32'h1, 1'b0,
            32'h0, 1'b1, 1, 1);
    alu_vec("add_c1", 4'd0, 32'hFFFFFFFF, 32'h1, 1'b1,
            32'h1, 1'b1, 1, 1);
    alu_vec("cmp_sub", 4'd9, ~32'd5, 32'd3, 1'b1,
            32'hFFFFFFFE, 1'b0, 1, 0);
    alu_vec("rsvd_add", 4'd15, 32'd1, 32'd2, 1'b1,
            32'd4, 1'b0, 1, 1);
    alu_vec("or", 4'd1, 32'hF0F0F0F0, 32'h0F0F0000, 1'b1,
            32'hFFFFF0F0, 1'b0, 1, 0);
    alu_vec("and", 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0,
            32'hF000F000, 1'b0, 1, 0);
    alu_vec("xor", 4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0,
            32'h0FF00FF0, 1'b0, 1, 0);
    alu_vec("sra", 4'd6, 32'h80000001, 32'h0, 1'b1,
            32'hC0000000, 1'b1, 1, 0);
    alu_vec("srl", 4'd7, 32'h80000001, 32'h0, 1'b1,
            32'h40000000, 1'b1, 1, 0);
    alu_vec("src", 4'd8, 32'h80000001, 32'h0, 1'b1,
            32'hC0000000, 1'b1, 1, 0);
    alu_vec("sext8", 4'd4, 32'h00000080, 32'h0, 1'b0,
            32'hFFFFFF80, 1'b0, 1, 0);
    alu_vec("sext16", 4'd5, 32'h00007FFF, 32'h0, 1'b0,
            32'h00007FFF, 1'b0, 1, 0);
    alu_vec("bsra", 4'd13, 32'h80000000, 32'd4, 1'b0,
            32'hF8000000, 1'b0, 0, 0);
    alu_vec("bsll", 4'd14, 32'h1, 32'd31, 1'b0,
            32'h80000000, 1'b0, 0, 0);
    alu_vec("bsrl_b5", 4'd12, 32'h80000000, 32'h24, 1'b0,
            32'h08000000, 1'b0, 0, 0);

    mul_vec("mul_wrap", 32'h00010000, 32'h00010000,
            32'h0, 0);
    mul_vec("mul_7x6", 32'd7, 32'd6, 32'h2A, 0);
    mul_vec("mul_stall", 32'd3, 32'd5, 32'hF, 2);

    @(posedge clk);
    #1;
    fns = 4'd11; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    fns = 4'd0;
    repeat (LAT + 2) @(posedge clk);

    cmp_vec("cmp_lt", 3'd2, 32'hFFFFFFFF, 32'h1, 1'b1);
    cmp_vec("cmp_gt", 3'd4, 32'hFFFFFFFF, 32'h1, 1'b0);
    cmp_vec("cmp_gtu", 3'd7, 32'hFFFFFFFF, 32'h1, 1'b1);
    cmp_vec("cmp_always", 3'd6, 32'hFFFFFFFF, 32'h1, 1'b1);
    cmp_vec("cmp_ne", 3'd1, 32'hFFFFFFFF, 32'h1, 1'b1);
    cmp_vec("cmp_eq0", 3'd0, 32'h0, 32'h1, 1'b1);
    cmp_vec("cmp_le0", 3'd3, 32'h0, 32'h1, 1'b1);
    cmp_vec("cmp_ge0", 3'd5, 32'h0, 32'h1, 1'b1);
    cmp_vec("cmp_gt0", 3'd4, 32'h0, 32'h1, 1'b0);
    cmp_vec("cmp_gtu_eq", 3'd7, 32'h1, 32'h1, 1'b0);

    repeat (3) @(posedge clk);
    fin_req = 1'b1;
    repeat (5) @(posedge clk);
    if (!fin_done) begin
      $display("FAIL monitor_final: final checks not run");
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
